// File: rtl/bus_qos_arbiter.sv
// Three-master QoS bus arbiter: SPI > DMEM > DMA base priority, aged requesters
// promoted, bounded hold time with forced handover only when others are waiting.
module bus_qos_arbiter #(
  parameter int unsigned MAX_HOLD  = 16,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_spi,
  output logic       o_gnt_spi,
  input  logic       i_req_dmem,
  output logic       o_gnt_dmem,
  input  logic       i_req_dma,
  output logic       o_gnt_dma,
  output logic [1:0] o_owner,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_SPI  = 2'd1,
    OWN_DMEM = 2'd2,
    OWN_DMA  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_SAT = 8'(MAX_HOLD - 1);
  localparam logic [7:0] AGE_SAT  = 8'(AGE_LIMIT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_hold;
  logic [7:0] r_wait [3];
  logic [2:0] r_gnt;

  logic [2:0] w_req;
  logic [2:0] w_aged;
  logic [2:0] w_own_mask;
  logic [2:0] w_others;
  logic       w_own_req;

  // Bit order everywhere: [0]=SPI, [1]=DMEM, [2]=DMA (also base priority order).
  assign w_req = {i_req_dma, i_req_dmem, i_req_spi};

  always_comb begin
    w_aged = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_aged[i] = (r_wait[i] == AGE_SAT);
    end
  end

  always_comb begin
    w_own_mask = '0;
    case (r_state)
      OWN_SPI:  w_own_mask = 3'b001;
      OWN_DMEM: w_own_mask = 3'b010;
      OWN_DMA:  w_own_mask = 3'b100;
      default:  w_own_mask = '0;
    endcase
  end

  assign w_others  = w_req & ~w_own_mask;
  assign w_own_req = |(w_req & w_own_mask);

  function automatic state_t pick(input logic [2:0] mask, input logic [2:0] aged);
    logic [2:0] aged_m;
    logic [2:0] cand;
    state_t     win;
    aged_m = mask & aged;
    cand   = (|aged_m) ? aged_m : mask;
    win    = IDLE;
    if (cand[0])      win = OWN_SPI;
    else if (cand[1]) win = OWN_DMEM;
    else if (cand[2]) win = OWN_DMA;
    return win;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = pick(w_req, w_aged);
      default: begin
        if (!w_own_req) begin
          w_next = pick(w_others, w_aged);
        end else if ((r_hold == HOLD_SAT) && (|w_others)) begin
          w_next = pick(w_others, w_aged);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
    end else begin
      r_state <= w_next;
      case (w_next)
        OWN_SPI:  r_gnt <= 3'b001;
        OWN_DMEM: r_gnt <= 3'b010;
        OWN_DMA:  r_gnt <= 3'b100;
        default:  r_gnt <= '0;
      endcase
    end
  end

  // Hold counter restarts on any entry into an OWN state, owner-to-owner included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold <= '0;
    end else if ((w_next != IDLE) && (w_next == r_state)) begin
      r_hold <= (r_hold == HOLD_SAT) ? HOLD_SAT : r_hold + 8'd1;
    end else begin
      r_hold <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        r_wait[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (w_req[i] && !w_own_mask[i]) begin
          r_wait[i] <= (r_wait[i] == AGE_SAT) ? AGE_SAT : r_wait[i] + 8'd1;
        end else begin
          r_wait[i] <= '0;
        end
      end
    end
  end

  assign o_owner    = r_state;
  assign o_gnt_spi  = r_gnt[0];
  assign o_gnt_dmem = r_gnt[1];
  assign o_gnt_dma  = r_gnt[2];
  assign o_busy     = |r_gnt;

endmodule

// File: tb/tb_bus_qos_arbiter.sv
// Scoreboard bench for bus_qos_arbiter: directed scenarios plus random traffic,
// expectations from an integer-level arbitration model.
module tb_bus_qos_arbiter;

  localparam int MH  = 16;
  localparam int AGE = 8;

  logic       clk;
  logic       rst_n;
  logic       req_spi, req_dmem, req_dma;
  logic       gnt_spi, gnt_dmem, gnt_dma;
  logic [1:0] owner;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // Reference model state: owner 0 none, 1 SPI, 2 DMEM, 3 DMA
  int m_owner;
  int m_hold;
  int m_wt[3];

  bus_qos_arbiter #(.MAX_HOLD(MH), .AGE_LIMIT(AGE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_spi  (req_spi),
    .o_gnt_spi  (gnt_spi),
    .i_req_dmem (req_dmem),
    .o_gnt_dmem (gnt_dmem),
    .i_req_dma  (req_dma),
    .o_gnt_dma  (gnt_dma),
    .o_owner    (owner),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] out_vec(input int own);
    logic [1:0] o;
    o = own[1:0];
    return {o, own == 1, own == 2, own == 3, own != 0};
  endfunction

  function automatic logic [5:0] act_vec();
    return {owner, gnt_spi, gnt_dmem, gnt_dma, busy};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got owner/gnt/busy=%b want=%b", name, $time, got, want);
    end
  endtask

  function automatic int pick(input int mask[3]);
    for (int i = 0; i < 3; i++)
      if (mask[i] != 0 && m_wt[i] >= AGE) return i + 1;
    for (int i = 0; i < 3; i++)
      if (mask[i] != 0) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_hold  = 0;
    for (int i = 0; i < 3; i++) m_wt[i] = 0;
  endtask

  task automatic model_step();
    int r[3];
    int others[3];
    int nxt;
    r[0] = int'(req_spi);
    r[1] = int'(req_dmem);
    r[2] = int'(req_dma);
    for (int i = 0; i < 3; i++) others[i] = (i + 1 == m_owner) ? 0 : r[i];
    if (m_owner == 0) begin
      nxt = pick(r);
    end else if (r[m_owner - 1] == 0) begin
      nxt = pick(others);
    end else if (m_hold < MH - 1) begin
      nxt = m_owner;
    end else begin
      nxt = pick(others);
      if (nxt == 0) nxt = m_owner;
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i] != 0 && m_owner != i + 1) m_wt[i] = (m_wt[i] + 1 > AGE) ? AGE : m_wt[i] + 1;
      else m_wt[i] = 0;
    end
    if (nxt != 0 && nxt == m_owner) m_hold = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
    else m_hold = 0;
    m_owner = nxt;
  endtask

  task automatic cyc(input bit s, input bit dm, input bit da);
    @(negedge clk);
    req_spi  = s;
    req_dmem = dm;
    req_dma  = da;
    model_step();
    exp_q.push_back(m_owner);
  endtask

  // Monitor: every sampled cycle out of reset consumes one expectation
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle", act_vec(), out_vec(e));
      end
    end
  end

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", act_vec(), 6'b0);
    model_reset();
    req_spi = 1'b0; req_dmem = 1'b0; req_dma = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("in_reset", act_vec(), 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit s, dm, da;
    rst_n = 1'b0;
    req_spi = 1'b0; req_dmem = 1'b0; req_dma = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_state", act_vec(), 6'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // DMEM beats DMA from idle
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Sole requester holds indefinitely
    repeat (40) cyc(0, 1, 0);
    cyc(0, 0, 0);

    // SPI drops while DMA waits: direct handover
    repeat (3) cyc(1, 0, 0);
    repeat (2) cyc(1, 0, 1);
    repeat (3) cyc(0, 0, 1);
    cyc(0, 0, 0);

    // DMA owner preempted by SPI only at hold limit
    repeat (4) cyc(0, 0, 1);
    repeat (16) cyc(1, 0, 1);
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 0);

    // Aged DMA wins over DMEM at SPI handover
    repeat (4) cyc(1, 0, 0);
    repeat (12) cyc(1, 0, 1);
    repeat (4) cyc(1, 1, 1);
    repeat (20) cyc(0, 1, 1);
    cyc(0, 0, 0);

    // Reset while DMEM owns the bus, then restart
    repeat (5) cyc(0, 1, 0);
    reset_pulse();
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Random sticky traffic
    s = 0; dm = 0; da = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) s  = ~s;
      if ($urandom_range(0, 5) == 0) dm = ~dm;
      if ($urandom_range(0, 5) == 0) da = ~da;
      cyc(s, dm, da);
    end
    cyc(0, 0, 0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_qos_arbiter.md
BUS_QOS_ARBITER -- requirements
Module: bus_qos_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, max consecutive grant cycles before forced handover when others wait (legal 2..255).
REQ-002 SHALL have parameter AGE_LIMIT, default 8, wait cycles after which a requester is "aged" (legal 1..255).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_req_spi  input  1  SPI slave master request.
REQ-006 SHALL have port o_gnt_spi  output  1  SPI grant.
REQ-007 SHALL have port i_req_dmem  input  1  RV DMEM master request.
REQ-008 SHALL have port o_gnt_dmem  output  1  RV DMEM grant.
REQ-009 SHALL have port i_req_dma  input  1  DMA master request.
REQ-010 SHALL have port o_gnt_dma  output  1  DMA grant.
REQ-011 SHALL have port o_owner  output  2  current owner: 0 none, 1 SPI, 2 DMEM, 3 DMA.
REQ-012 SHALL have port o_busy  output  1  high when any grant asserted.

Function
REQ-013 SHALL implement FSM states IDLE, OWN_SPI, OWN_DMEM, OWN_DMA; o_owner equals state encoding 0/1/2/3.
REQ-014 SHALL drive grants as registered decodes of state; at most one grant high in any cycle; o_busy = OR of grants.
REQ-015 SHALL have base priority SPI > DMEM > DMA.
REQ-016 SHALL have winner selection: aged requesters beat non-aged; ties within a class resolved by base priority.
REQ-017 SHALL, in IDLE, with any request high in cycle N, move to the winner's state; grant visible in cycle N+1.
REQ-018 SHALL, in OWN_X with i_req_X low, re-arbitrate among remaining requesters in the same cycle; next state is winner or IDLE; no idle bubble between owners.
REQ-019 SHALL, in OWN_X with i_req_X high, give no preemption while hold_cnt < MAX_HOLD-1, even by a higher-priority or aged requester.
REQ-020 SHALL, in OWN_X with i_req_X high, hold_cnt == MAX_HOLD-1 and another request pending, move to the winner among the others, current owner excluded.
REQ-021 SHALL, in OWN_X with i_req_X high, hold_cnt == MAX_HOLD-1 and no other request, keep ownership; hold_cnt saturates.
REQ-022 SHALL have hold_cnt (8 bit): cleared on every state change into an OWN state, including owner-to-owner; increments each cycle in an OWN state; saturates at MAX_HOLD-1.
REQ-023 SHALL have one wait counter per requester (8 bit): increments when req high and not granted; saturates at AGE_LIMIT; clears when granted or req low.
REQ-024 SHALL define a requester as aged when its wait counter == AGE_LIMIT.
REQ-025 SHALL treat a request dropping in the same cycle its grant would be decided as not pending; no grant issued to it.
REQ-026 SHALL make all selection purely combinational on the current req inputs and registered counters; no combinational path from req inputs to grant outputs.

Reset
REQ-027 SHALL, while i_rst_n low: state IDLE, all grants 0, o_owner 0, o_busy 0, hold_cnt 0, all wait counters 0.
REQ-028 SHALL, on reset assertion mid-grant, drop the grant immediately (asynchronously); first grant after deassertion no earlier than one cycle after the first sampled request.

Verification
REQ-029 SHALL cover: from IDLE, i_req_dmem and i_req_dma raised in cycle 0 -> o_gnt_dmem=1, o_owner=2 in cycle 1; o_gnt_dma=0.
REQ-030 SHALL cover: OWN_DMA, i_req_dma high, i_req_spi raised at hold_cnt=3, MAX_HOLD=16 -> o_gnt_dma held until hold_cnt=15; o_gnt_spi=1 on the next cycle, with no idle cycle between.
REQ-031 SHALL cover: OWN_SPI, i_req_spi drops while i_req_dma high -> o_gnt_dma=1 the following cycle, o_busy stays 1 throughout.
REQ-032 SHALL cover: AGE_LIMIT=8, i_req_dma waiting 8 cycles during an SPI hold, then SPI and DMEM both request at handover -> DMA granted before DMEM.
REQ-033 SHALL cover: sole requester DMEM held 40 cycles with MAX_HOLD=16 -> continuous o_gnt_dmem for 40 cycles, hold_cnt saturated at 15.
REQ-034 SHALL cover: i_rst_n pulsed low during OWN_DMEM -> o_gnt_dmem falls without a clock edge; all outputs 0 until a request is sampled after release.
